// File: rtl/data_mem_if.sv
// Data-memory request/response bus between the memory stage (master)
// and the data-memory responder (slave).
interface data_mem_if;
   logic        data_mem_req_i;
   logic [63:0] data_mem_addr_i;
   logic [2:0]  data_mem_row_idx_i;
   logic [1:0]  data_mem_size_i;
   logic        data_mem_wr_i;
   logic [63:0] data_mem_wr_data_i;
   logic        data_mem_ready_o;
   logic        data_mem_rsp_valid_o;
   logic [63:0] data_mem_rd_data_o;
   logic        data_mem_rsp_err_o;

   modport master (
      output data_mem_req_i, data_mem_addr_i, data_mem_row_idx_i,
             data_mem_size_i, data_mem_wr_i, data_mem_wr_data_i,
      input  data_mem_ready_o, data_mem_rsp_valid_o, data_mem_rd_data_o,
             data_mem_rsp_err_o
   );

   modport slave (
      input  data_mem_req_i, data_mem_addr_i, data_mem_row_idx_i,
             data_mem_size_i, data_mem_wr_i, data_mem_wr_data_i,
      output data_mem_ready_o, data_mem_rsp_valid_o, data_mem_rd_data_o,
             data_mem_rsp_err_o
   );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-masked 64-bit SRAM with fixed read latency.
// Optional error responses (misalignment / out of range) under DATA_MEM_ERR_RSP_EN.
module data_mem_resp #(
   parameter int MEM_SIZE   = 524288,
   parameter int RD_LATENCY = 1
) (
   input  logic      clk,
   input  logic      reset,
   data_mem_if.slave bus
);

   localparam int ROWS  = MEM_SIZE / 8;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [63:0]      pend_data_q;
   logic [63:0]      rd_data_q;
   logic             accept;
   logic             load_now, load_pend;
   logic [ROW_W-1:0] row;
   logic [5:0]       shamt;
   logic [7:0]       size_mask, byte_mask;
   logic [63:0]      wr_data_sh;
   logic [63:0]      rd_now;
   logic             req_err;
   logic             unused_addr_bits;

   logic [63:0] mem [ROWS];

   assign bus.data_mem_ready_o     = (state_q != WAIT);
   assign bus.data_mem_rsp_valid_o = (state_q == RESP);
   assign bus.data_mem_rd_data_o   = rd_data_q;

   assign accept           = bus.data_mem_req_i && bus.data_mem_ready_o;
   assign row              = bus.data_mem_addr_i[ROW_W+2:3];
   assign shamt            = {bus.data_mem_row_idx_i, 3'b000};
   assign wr_data_sh       = bus.data_mem_wr_data_i << shamt;
   assign byte_mask        = size_mask << bus.data_mem_row_idx_i;
   assign unused_addr_bits = ^{bus.data_mem_addr_i[63:ROW_W+3], bus.data_mem_addr_i[2:0]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      size_mask = 8'h01;
      case (bus.data_mem_size_i)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

`ifdef DATA_MEM_ERR_RSP_EN
   logic misaligned;
   logic pend_err_q;
   logic rsp_err_q;

   always_comb begin
      misaligned = 1'b0;
      case (bus.data_mem_size_i)
         2'd1:    misaligned = bus.data_mem_row_idx_i[0];
         2'd2:    misaligned = |bus.data_mem_row_idx_i[1:0];
         2'd3:    misaligned = |bus.data_mem_row_idx_i;
         default: misaligned = 1'b0;
      endcase
   end

   assign req_err = misaligned || (bus.data_mem_addr_i >= 64'(MEM_SIZE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_err_q <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept)    pend_err_q <= req_err;
         if (load_now)  rsp_err_q  <= req_err;
         if (load_pend) rsp_err_q  <= pend_err_q;
      end
   end

   assign bus.data_mem_rsp_err_o = rsp_err_q;
`else
   assign req_err                = 1'b0;
   assign bus.data_mem_rsp_err_o = 1'b0;
`endif

   // Stores and errored requests answer with zero data.
   assign rd_now = (bus.data_mem_wr_i || req_err) ? 64'd0 : (mem[row] >> shamt);

   // NOTE: the array is deliberately not reset; only control state is.
   always_ff @(posedge clk) begin
      if (accept && bus.data_mem_wr_i && !req_err) begin
         for (int b = 0; b < 8; b++) begin
            if (byte_mask[b]) mem[row][b*8 +: 8] <= wr_data_sh[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load_now  = 1'b0;
      load_pend = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (accept) begin
               if (bus.data_mem_wr_i || RD_LATENCY == 1) begin
                  state_d  = RESP;
                  load_now = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'(RD_LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d   = RESP;
               load_pend = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         pend_data_q <= 64'd0;
         rd_data_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Read data is captured at acceptance, so it reflects any store accepted just before.
         if (accept)    pend_data_q <= rd_now;
         if (load_now)  rd_data_q   <= rd_now;
         if (load_pend) rd_data_q   <= pend_data_q;
      end
   end

endmodule
